// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: latch controls, PC enable, halt and perf counters.
// Ports: CLK/nRST, cache handshakes, hazard inputs -> fd/de/em/mw states, pc_en, halted, counters.
package hazard_pkg;
  typedef enum logic [1:0] {
    PIPE_NORMAL = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_FLUSH  = 2'd2
  } pipe_state_t;
endpackage

module hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             dREN_ex,
  input  logic [4:0]       regWSEL_ex,
  input  logic [4:0]       rs_dec,
  input  logic [4:0]       rt_dec,
  input  logic             uses_rt_dec,
  input  logic             branch_taken_mem,
  input  logic             halt_mem,
  output pipe_state_t      fd_state,
  output pipe_state_t      de_state,
  output pipe_state_t      em_state,
  output pipe_state_t      mw_state,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DWAIT = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t r_state;

  logic w_in_halt;
  logic w_mwait;
  logic w_hlt;
  logic w_br;
  logic w_lu;
  logic w_miss;
  logic w_dep;

  // Rule terms are made mutually exclusive so the decoder is one-hot.
  assign w_in_halt = (r_state == S_HALT);
  assign w_dep = dREN_ex && (regWSEL_ex != 5'd0) &&
                 ((regWSEL_ex == rs_dec) ||
                  (uses_rt_dec && (regWSEL_ex == rt_dec)));
  assign w_mwait = !w_in_halt && (dREN_mem || dWEN_mem) && !dhit;
  assign w_hlt = !w_in_halt && !w_mwait && halt_mem;
  assign w_br = !w_in_halt && !w_mwait && !halt_mem &&
                branch_taken_mem;
  assign w_lu = !w_in_halt && !w_mwait && !halt_mem &&
                !branch_taken_mem && w_dep;
  assign w_miss = !w_in_halt && !w_mwait && !halt_mem &&
                  !branch_taken_mem && !w_dep && !ihit;

  always_comb begin
    fd_state = PIPE_NORMAL;
    de_state = PIPE_NORMAL;
    em_state = PIPE_NORMAL;
    mw_state = PIPE_NORMAL;
    pc_en    = 1'b1;
    if (!nRST) begin
      fd_state = PIPE_FLUSH;
      de_state = PIPE_FLUSH;
      em_state = PIPE_FLUSH;
      mw_state = PIPE_FLUSH;
      pc_en    = 1'b0;
    end else begin
      unique case (1'b1)
        w_in_halt: begin
          fd_state = PIPE_STALL;
          de_state = PIPE_STALL;
          em_state = PIPE_STALL;
          mw_state = PIPE_STALL;
          pc_en    = 1'b0;
        end
        w_mwait: begin
          fd_state = PIPE_STALL;
          de_state = PIPE_STALL;
          em_state = PIPE_STALL;
          mw_state = PIPE_FLUSH;
          pc_en    = 1'b0;
        end
        w_hlt: begin
          fd_state = PIPE_FLUSH;
          de_state = PIPE_FLUSH;
          em_state = PIPE_FLUSH;
          pc_en    = 1'b0;
        end
        w_br: begin
          fd_state = PIPE_FLUSH;
          de_state = PIPE_FLUSH;
          em_state = PIPE_FLUSH;
        end
        w_lu: begin
          fd_state = PIPE_STALL;
          de_state = PIPE_FLUSH;
          pc_en    = 1'b0;
        end
        w_miss: begin
          fd_state = PIPE_FLUSH;
          pc_en    = 1'b0;
        end
        default: begin
          pc_en = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_RUN;
      halted    <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!w_in_halt) begin
        cycle_cnt <= cycle_cnt + 1'b1;
        if (!pc_en) stall_cnt <= stall_cnt + 1'b1;
        if (w_br) flush_cnt <= flush_cnt + 1'b1;
      end
      if (w_in_halt) begin
        r_state <= S_HALT;
        halted  <= 1'b1;
      end else if (w_mwait) begin
        r_state <= S_DWAIT;
        halted  <= 1'b0;
      end else if (w_hlt) begin
        r_state <= S_HALT;
        halted  <= 1'b1;
      end else begin
        r_state <= S_RUN;
        halted  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized + directed bench for hazard_controller against a rule-table model.
// Small counter width so wraparound is exercised.
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam int CW = 4;
  localparam int MSK = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit = 1'b1, dhit = 1'b0;
  logic dREN_mem = 1'b0, dWEN_mem = 1'b0, dREN_ex = 1'b0;
  logic [4:0] regWSEL_ex = '0, rs_dec = '0, rt_dec = '0;
  logic uses_rt_dec = 1'b0, branch_taken_mem = 1'b0, halt_mem = 1'b0;
  pipe_state_t fd_state, de_state, em_state, mw_state;
  logic pc_en, halted;
  logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail = 0;

  int m_halt = 0;
  int m_cyc = 0, m_stl = 0, m_fl = 0;
  int m_rule;
  logic [8:0] out_tab [8];

  hazard_controller #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
    .regWSEL_ex(regWSEL_ex), .rs_dec(rs_dec), .rt_dec(rt_dec),
    .uses_rt_dec(uses_rt_dec), .branch_taken_mem(branch_taken_mem),
    .halt_mem(halt_mem), .fd_state(fd_state), .de_state(de_state),
    .em_state(em_state), .mw_state(mw_state), .pc_en(pc_en),
    .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rule_of();
    if (!nRST) return 0;
    if (m_halt != 0) return 1;
    if ((dREN_mem || dWEN_mem) && !dhit) return 2;
    if (halt_mem) return 3;
    if (branch_taken_mem) return 4;
    if (dREN_ex && regWSEL_ex != 0 &&
        (regWSEL_ex == rs_dec ||
         (uses_rt_dec && regWSEL_ex == rt_dec))) return 5;
    if (!ihit) return 6;
    return 7;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc(input string tag);
    logic [8:0] got;
    @(negedge CLK);
    #1;
    if (!nRST) begin
      m_halt = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
    end
    m_rule = rule_of();
    got = {fd_state, de_state, em_state, mw_state, pc_en};
    chk({tag, ".ctl"}, 32'(got), 32'(out_tab[m_rule]));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    chk({tag, ".cyc"}, 32'(cycle_cnt), 32'(m_cyc));
    chk({tag, ".stl"}, 32'(stall_cnt), 32'(m_stl));
    chk({tag, ".fl"}, 32'(flush_cnt), 32'(m_fl));
    @(posedge CLK);
    if (nRST && m_halt == 0) begin
      m_cyc = (m_cyc + 1) & MSK;
      if (out_tab[m_rule][0] == 1'b0) m_stl = (m_stl + 1) & MSK;
      if (m_rule == 4) m_fl = (m_fl + 1) & MSK;
      if (m_rule == 3) m_halt = 1;
    end
    #1;
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; dREN_mem = 0; dWEN_mem = 0; dREN_ex = 0;
    regWSEL_ex = 0; rs_dec = 0; rt_dec = 0; uses_rt_dec = 0;
    branch_taken_mem = 0; halt_mem = 0;
  endtask

  initial begin
    // {fd,de,em,mw,pc_en}, N=0 S=1 F=2
    out_tab[0] = {2'd2, 2'd2, 2'd2, 2'd2, 1'b0};
    out_tab[1] = {2'd1, 2'd1, 2'd1, 2'd1, 1'b0};
    out_tab[2] = {2'd1, 2'd1, 2'd1, 2'd2, 1'b0};
    out_tab[3] = {2'd2, 2'd2, 2'd2, 2'd0, 1'b0};
    out_tab[4] = {2'd2, 2'd2, 2'd2, 2'd0, 1'b1};
    out_tab[5] = {2'd1, 2'd2, 2'd0, 2'd0, 1'b0};
    out_tab[6] = {2'd2, 2'd0, 2'd0, 2'd0, 1'b0};
    out_tab[7] = {2'd0, 2'd0, 2'd0, 2'd0, 1'b1};

    idle();
    nRST = 0;
    repeat (3) cyc("reset");
    nRST = 1;
    repeat (3) cyc("run");

    dREN_ex = 1; regWSEL_ex = 5; rs_dec = 5;
    cyc("loaduse");
    regWSEL_ex = 0; rs_dec = 0;
    cyc("lu_r0");
    idle();

    dREN_mem = 1;
    repeat (4) cyc("dwait");
    dhit = 1;
    cyc("dwait_hit");
    idle();

    branch_taken_mem = 1; ihit = 0;
    dREN_ex = 1; regWSEL_ex = 7; rt_dec = 7; uses_rt_dec = 1;
    cyc("branch");
    idle();

    halt_mem = 1; dWEN_mem = 1;
    repeat (2) cyc("halt_wait");
    dhit = 1;
    cyc("halt_flush");
    idle();
    repeat (3) cyc("halted");
    nRST = 0;
    cyc("halt_rst");
    nRST = 1;
    cyc("post_rst");

    ihit = 0;
    repeat (3) cyc("fmiss");
    idle();
    cyc("fmiss_end");

    for (int i = 0; i < 1500; i++) begin
      ihit = ($urandom_range(0, 3) != 0);
      dhit = $urandom_range(0, 1);
      dREN_mem = ($urandom_range(0, 3) == 0);
      dWEN_mem = ($urandom_range(0, 5) == 0);
      dREN_ex = $urandom_range(0, 1);
      regWSEL_ex = 5'($urandom_range(0, 3));
      rs_dec = 5'($urandom_range(0, 3));
      rt_dec = 5'($urandom_range(0, 3));
      uses_rt_dec = $urandom_range(0, 1);
      branch_taken_mem = ($urandom_range(0, 5) == 0);
      halt_mem = ($urandom_range(0, 60) == 0);
      if (m_halt != 0) nRST = ($urandom_range(0, 5) != 0);
      else nRST = ($urandom_range(0, 150) != 0);
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
